// File: rtl/quidditch_score_ctrl_if.sv
// rtl/quidditch_score_ctrl_if.sv - button and score signal bundle for quidditch_score_ctrl
// Purpose: groups the game inputs (new_game and the six active-low buttons) and the
//          score/status outputs so the controller and its driver share one port.
// Signals: new_game, goal_n[1:0], snitch_n[1:0], foul_n[1:0]   (driver -> controller)
//          score_a, score_b [W-1:0], upd_valid, upd_team, busy,
//          game_over, winner[1:0]                              (controller -> driver)
// Modports: slave = controller side, master = board/driver side.
interface quidditch_score_ctrl_if #(
  parameter int W = 14
);
  logic         new_game;
  logic [1:0]   goal_n;
  logic [1:0]   snitch_n;
  logic [1:0]   foul_n;
  logic [W-1:0] score_a;
  logic [W-1:0] score_b;
  logic         upd_valid;
  logic         upd_team;
  logic         busy;
  logic         game_over;
  logic [1:0]   winner;

  modport slave (
    input  new_game, goal_n, snitch_n, foul_n,
    output score_a, score_b, upd_valid, upd_team, busy, game_over, winner
  );

  modport master (
    output new_game, goal_n, snitch_n, foul_n,
    input  score_a, score_b, upd_valid, upd_team, busy, game_over, winner
  );
endinterface

// File: rtl/quidditch_score_ctrl.sv
// rtl/quidditch_score_ctrl.sv - two-team score controller with event queue and round-robin
// Purpose: synchronizes six raw buttons, latches falling edges as pending events, grants one
//          event at a time (round-robin between teams, snitch > goal > foul within a team)
//          and applies it to the saturating score registers. A snitch ends the game.
// Ports:   clk   - system clock
//          reset - asynchronous active-low reset
//          bus   - quidditch_score_ctrl_if.slave (buttons, new_game, scores, status)
module quidditch_score_ctrl #(
  parameter int W          = 14,
  parameter int MAX_SCORE  = 9999,
  parameter int GOAL_PTS   = 10,
  parameter int SNITCH_PTS = 150,
  parameter int FOUL_PTS   = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  quidditch_score_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_OVER} state_t;

  // Event type code; flag index is {type, team}.
  localparam logic [1:0] T_GOAL   = 2'd0;
  localparam logic [1:0] T_SNITCH = 2'd1;
  localparam logic [1:0] T_FOUL   = 2'd2;

  localparam logic [W:0] L_MAX    = (W+1)'(MAX_SCORE);
  localparam logic [W:0] L_GOAL   = (W+1)'(GOAL_PTS);
  localparam logic [W:0] L_SNITCH = (W+1)'(SNITCH_PTS);
  localparam logic [W:0] L_FOUL   = (W+1)'(FOUL_PTS);

  state_t       r_state, w_state_next;
  logic [5:0]   r_sync1, r_sync2, r_sync3;
  logic [5:0]   r_pend;
  logic         r_last_grant;
  logic         r_grant_team;
  logic [1:0]   r_grant_type;
  logic [W-1:0] r_score_a, r_score_b;
  logic         r_upd_valid, r_upd_team;
  logic [1:0]   r_winner;

  logic [5:0]   w_btn_n, w_fall, w_clr;
  logic         w_pend_a, w_pend_b, w_team;
  logic [2:0]   w_team_pend;
  logic [1:0]   w_type;
  logic [W-1:0] w_cur, w_new, w_new_a, w_new_b;
  logic [W:0]   w_sum;
  logic [1:0]   w_winner;

  // Bit order: [1:0] goal, [3:2] snitch, [5:4] foul; even bits team A, odd bits team B.
  assign w_btn_n  = {bus.foul_n, bus.snitch_n, bus.goal_n};
  assign w_fall   = r_sync3 & ~r_sync2;
  assign w_pend_a = r_pend[0] | r_pend[2] | r_pend[4];
  assign w_pend_b = r_pend[1] | r_pend[3] | r_pend[5];

  // With both teams waiting, serve the team that did not get the last grant.
  assign w_team      = (w_pend_a && w_pend_b) ? ~r_last_grant : w_pend_b;
  assign w_team_pend = w_team ? {r_pend[5], r_pend[3], r_pend[1]}
                              : {r_pend[4], r_pend[2], r_pend[0]};
  assign w_type      = w_team_pend[1] ? T_SNITCH : (w_team_pend[0] ? T_GOAL : T_FOUL);

  assign w_cur = r_grant_team ? r_score_b : r_score_a;
  assign w_sum = {1'b0, w_cur} + ((r_grant_type == T_SNITCH) ? L_SNITCH : L_GOAL);

  always_comb begin
    w_new = w_cur;
    if (r_grant_type == T_FOUL) begin
      w_new = ({1'b0, w_cur} < L_FOUL) ? '0 : (w_cur - L_FOUL[W-1:0]);
    end else begin
      w_new = (w_sum > L_MAX) ? L_MAX[W-1:0] : w_sum[W-1:0];
    end
  end

  assign w_new_a  = r_grant_team ? r_score_a : w_new;
  assign w_new_b  = r_grant_team ? w_new : r_score_b;
  assign w_winner = (w_new_a > w_new_b) ? 2'b01 : ((w_new_b > w_new_a) ? 2'b10 : 2'b11);

  always_comb begin
    w_clr = '0;
    if (r_state == S_APPLY) w_clr[{r_grant_type, r_grant_team}] = 1'b1;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (|r_pend) w_state_next = S_APPLY;
      S_APPLY: w_state_next = (r_grant_type == T_SNITCH) ? S_OVER : S_IDLE;
      S_OVER:  w_state_next = S_OVER;
      default: w_state_next = S_IDLE;
    endcase
    if (bus.new_game) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // Synchronizers idle high (released buttons) so reset release makes no edge.
      r_sync1      <= '1;
      r_sync2      <= '1;
      r_sync3      <= '1;
      r_pend       <= '0;
      r_last_grant <= 1'b1;
      r_grant_team <= 1'b0;
      r_grant_type <= T_GOAL;
      r_score_a    <= '0;
      r_score_b    <= '0;
      r_upd_valid  <= 1'b0;
      r_upd_team   <= 1'b0;
      r_winner     <= 2'b00;
    end else begin
      r_sync1     <= w_btn_n;
      r_sync2     <= r_sync1;
      r_sync3     <= r_sync2;
      r_upd_valid <= 1'b0;
      if (bus.new_game) begin
        // Overrides everything, including an APPLY in flight.
        r_pend       <= '0;
        r_last_grant <= 1'b1;
        r_score_a    <= '0;
        r_score_b    <= '0;
        r_winner     <= 2'b00;
      end else begin
        // OR-ing the new edges after the clear lets a same-cycle set win.
        if (r_state == S_OVER) r_pend <= '0;
        else                   r_pend <= (r_pend & ~w_clr) | w_fall;
        if (r_state == S_IDLE && |r_pend) begin
          r_grant_team <= w_team;
          r_grant_type <= w_type;
        end
        if (r_state == S_APPLY) begin
          r_score_a    <= w_new_a;
          r_score_b    <= w_new_b;
          r_upd_valid  <= 1'b1;
          r_upd_team   <= r_grant_team;
          r_last_grant <= r_grant_team;
          if (r_grant_type == T_SNITCH) r_winner <= w_winner;
        end
      end
    end
  end

  assign bus.score_a   = r_score_a;
  assign bus.score_b   = r_score_b;
  assign bus.upd_valid = r_upd_valid;
  assign bus.upd_team  = r_upd_team;
  assign bus.busy      = (|r_pend) | (r_state == S_APPLY);
  assign bus.game_over = (r_state == S_OVER);
  assign bus.winner    = r_winner;

endmodule

// File: tb/tb_quidditch_score_ctrl.sv
// tb/tb_quidditch_score_ctrl.sv - directed, table-driven bench for quidditch_score_ctrl
module tb_quidditch_score_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  quidditch_score_ctrl_if #(.W(14)) bus ();

  quidditch_score_ctrl #(
    .W(14), .MAX_SCORE(9999), .GOAL_PTS(10), .SNITCH_PTS(150), .FOUL_PTS(10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  g;
    logic [1:0]  s;
    logic [1:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] go;
    logic [31:0] win;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the given (active-high mask) buttons low for one clock, then release.
  task automatic press(input logic [1:0] g, input logic [1:0] s, input logic [1:0] f);
    bus.goal_n   = ~g;
    bus.snitch_n = ~s;
    bus.foul_n   = ~f;
    cyc(1);
    bus.goal_n   = 2'b11;
    bus.snitch_n = 2'b11;
    bus.foul_n   = 2'b11;
  endtask

  task automatic restart();
    bus.new_game = 1'b1;
    cyc(1);
    bus.new_game = 1'b0;
    cyc(1);
  endtask

  initial begin
    //         g      s      f      a     b     go  win
    vecs[0]  = '{2'b01, 2'b00, 2'b00, 10,   0,    0, 0};  // A goal
    vecs[1]  = '{2'b10, 2'b00, 2'b00, 0,    10,   0, 0};  // B goal
    vecs[2]  = '{2'b11, 2'b00, 2'b00, 10,   10,   0, 0};  // both goals
    vecs[3]  = '{2'b00, 2'b00, 2'b01, 0,    0,    0, 0};  // A foul floors at 0
    vecs[4]  = '{2'b00, 2'b10, 2'b00, 0,    150,  1, 2};  // B snitch
    vecs[5]  = '{2'b01, 2'b01, 2'b00, 150,  0,    1, 1};  // A goal+snitch: snitch first, goal lost
    vecs[6]  = '{2'b11, 2'b11, 2'b11, 150,  0,    1, 1};  // everything: A snitch ends it
    vecs[7]  = '{2'b01, 2'b00, 2'b01, 0,    0,    0, 0};  // A goal then foul
    vecs[8]  = '{2'b10, 2'b00, 2'b10, 0,    0,    0, 0};  // B goal then foul
    vecs[9]  = '{2'b00, 2'b11, 2'b00, 150,  0,    1, 1};  // both snitch: A first
    vecs[10] = '{2'b01, 2'b10, 2'b00, 10,   150,  1, 2};  // A goal, then B snitch

    reset        = 1'b0;
    bus.new_game = 1'b0;
    bus.goal_n   = 2'b11;
    bus.snitch_n = 2'b11;
    bus.foul_n   = 2'b11;
    cyc(2);
    chk("rst_score_a", 32'(bus.score_a), 0);
    chk("rst_score_b", 32'(bus.score_b), 0);
    chk("rst_upd_valid", 32'(bus.upd_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_game_over", 32'(bus.game_over), 0);
    chk("rst_winner", 32'(bus.winner), 0);
    reset = 1'b1;
    cyc(2);

    // Latency: pin -> pending in 3 edges, score write 2 edges later.
    bus.goal_n = 2'b10;
    cyc(1);
    bus.goal_n = 2'b11;
    cyc(1);
    chk("lat_busy_e2", 32'(bus.busy), 0);
    cyc(1);
    chk("lat_busy_e3", 32'(bus.busy), 1);
    chk("lat_upd_e3", 32'(bus.upd_valid), 0);
    cyc(1);
    chk("lat_upd_e4", 32'(bus.upd_valid), 0);
    chk("lat_a_e4", 32'(bus.score_a), 0);
    cyc(1);
    chk("lat_upd_e5", 32'(bus.upd_valid), 1);
    chk("lat_team_e5", 32'(bus.upd_team), 0);
    chk("lat_a_e5", 32'(bus.score_a), 10);
    chk("lat_b_e5", 32'(bus.score_b), 0);
    cyc(1);
    chk("lat_upd_e6", 32'(bus.upd_valid), 0);
    chk("lat_busy_e6", 32'(bus.busy), 0);

    // Simultaneous goals: A at edge 5, B two edges later.
    restart();
    press(2'b11, 2'b00, 2'b00);
    cyc(4);
    chk("rr_upd1", 32'(bus.upd_valid), 1);
    chk("rr_team1", 32'(bus.upd_team), 0);
    chk("rr_b1", 32'(bus.score_b), 0);
    cyc(1);
    chk("rr_gap", 32'(bus.upd_valid), 0);
    cyc(1);
    chk("rr_upd2", 32'(bus.upd_valid), 1);
    chk("rr_team2", 32'(bus.upd_team), 1);
    chk("rr_a2", 32'(bus.score_a), 10);
    chk("rr_b2", 32'(bus.score_b), 10);

    // Table of single press patterns, each from a fresh game.
    for (int i = 0; i < 11; i++) begin
      restart();
      press(vecs[i].g, vecs[i].s, vecs[i].f);
      cyc(20);
      chk($sformatf("vec%0d_a", i), 32'(bus.score_a), vecs[i].a);
      chk($sformatf("vec%0d_b", i), 32'(bus.score_b), vecs[i].b);
      chk($sformatf("vec%0d_over", i), 32'(bus.game_over), vecs[i].go);
      chk($sformatf("vec%0d_winner", i), 32'(bus.winner), vecs[i].win);
      chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 0);
    end

    // Game over freezes scores and swallows new presses.
    press(2'b11, 2'b00, 2'b11);
    cyc(10);
    chk("over_a", 32'(bus.score_a), 10);
    chk("over_b", 32'(bus.score_b), 150);
    chk("over_busy", 32'(bus.busy), 0);
    chk("over_go", 32'(bus.game_over), 1);

    // Saturation at 9999, then foul from the ceiling.
    restart();
    for (int i = 0; i < 999; i++) begin
      press(2'b10, 2'b00, 2'b00);
      cyc(3);
    end
    cyc(6);
    chk("sat_9990", 32'(bus.score_b), 9990);
    press(2'b10, 2'b00, 2'b00);
    cyc(8);
    chk("sat_clamp", 32'(bus.score_b), 9999);
    press(2'b10, 2'b00, 2'b00);
    cyc(8);
    chk("sat_hold", 32'(bus.score_b), 9999);
    press(2'b00, 2'b00, 2'b10);
    cyc(8);
    chk("sat_foul", 32'(bus.score_b), 9989);
    chk("sat_a", 32'(bus.score_a), 0);

    // new_game while APPLY is in flight: write discarded.
    restart();
    press(2'b01, 2'b00, 2'b00);
    cyc(8);
    chk("ng_pre_a", 32'(bus.score_a), 10);
    press(2'b01, 2'b00, 2'b00);
    cyc(3);
    chk("ng_apply_busy", 32'(bus.busy), 1);
    bus.new_game = 1'b1;
    cyc(1);
    bus.new_game = 1'b0;
    chk("ng_upd", 32'(bus.upd_valid), 0);
    chk("ng_a", 32'(bus.score_a), 0);
    chk("ng_busy", 32'(bus.busy), 0);
    chk("ng_over", 32'(bus.game_over), 0);
    cyc(1);
    chk("ng_upd_next", 32'(bus.upd_valid), 0);
    press(2'b01, 2'b00, 2'b00);
    cyc(8);
    chk("ng_resume_a", 32'(bus.score_a), 10);

    // Async reset mid-game with last grant on A; afterwards A must win the tie.
    restart();
    for (int i = 0; i < 2; i++) begin
      press(2'b10, 2'b00, 2'b00);
      cyc(7);
    end
    for (int i = 0; i < 4; i++) begin
      press(2'b01, 2'b00, 2'b00);
      cyc(7);
    end
    chk("ar_pre_a", 32'(bus.score_a), 40);
    chk("ar_pre_b", 32'(bus.score_b), 20);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_a", 32'(bus.score_a), 0);
    chk("ar_b", 32'(bus.score_b), 0);
    chk("ar_upd", 32'(bus.upd_valid), 0);
    chk("ar_team", 32'(bus.upd_team), 0);
    chk("ar_busy", 32'(bus.busy), 0);
    chk("ar_over", 32'(bus.game_over), 0);
    chk("ar_winner", 32'(bus.winner), 0);
    reset = 1'b1;
    cyc(2);
    press(2'b11, 2'b00, 2'b00);
    cyc(4);
    chk("ar_tie_upd", 32'(bus.upd_valid), 1);
    chk("ar_tie_team", 32'(bus.upd_team), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
